// File: rtl/bp_me_mem_cmd_arbiter.sv
// rtl/bp_me_mem_cmd_arbiter.sv - round-robin memory command arbiter with in-order response routing
// Grants one CCE per cycle into a one-entry command slot and tracks granted IDs for response return.
module bp_me_mem_cmd_arbiter #(
  parameter int num_req_p         = 2,
  parameter int cmd_width_p       = 128,
  parameter int resp_width_p      = 128,
  parameter int max_outstanding_p = 4
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [num_req_p*cmd_width_p-1:0]     req_cmd_i,
  input  logic [num_req_p-1:0]                 req_cmd_v_i,
  output logic [num_req_p-1:0]                 req_cmd_yumi_o,
  output logic [cmd_width_p-1:0]               mem_cmd_o,
  output logic                                 mem_cmd_v_o,
  input  logic                                 mem_cmd_ready_i,
  input  logic [resp_width_p-1:0]              mem_resp_i,
  input  logic                                 mem_resp_v_i,
  output logic                                 mem_resp_ready_o,
  output logic [resp_width_p-1:0]              req_resp_o,
  output logic [num_req_p-1:0]                 req_resp_v_o,
  input  logic [num_req_p-1:0]                 req_resp_ready_i,
  output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o
);

  localparam int id_w_lp  = $clog2(num_req_p);
  localparam int ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);

  logic [cmd_width_p-1:0] req_cmd_arr [num_req_p];
  for (genvar k = 0; k < num_req_p; k++) begin : g_unpack
    assign req_cmd_arr[k] = req_cmd_i[k*cmd_width_p +: cmd_width_p];
  end

  logic [cmd_width_p-1:0] mem_cmd_q, mem_cmd_d;
  logic                   mem_cmd_v_q, mem_cmd_v_d;
  logic [id_w_lp-1:0]     rr_ptr_q, rr_ptr_d;
  logic [id_w_lp-1:0]     fifo_q [max_outstanding_p];
  logic [id_w_lp-1:0]     fifo_d [max_outstanding_p];
  logic [ptr_w_lp-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [cnt_w_lp-1:0]    count_q, count_d;

  logic               grant_en, grant_found, grant, pop, fifo_nonempty;
  logic [id_w_lp:0]   scan;
  logic [id_w_lp-1:0] grant_idx, head;

  assign fifo_nonempty = (count_q != '0);
  assign head          = fifo_q[rd_ptr_q];

  // Occupancy is checked against the registered count, so a same-cycle pop never enables a grant.
  assign grant_en = reset_n_i & (~mem_cmd_v_q | mem_cmd_ready_i) &
                    (count_q < cnt_w_lp'(max_outstanding_p));

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    for (int i = 0; i < num_req_p; i++) begin
      scan = {1'b0, rr_ptr_q} + (id_w_lp+1)'(i);
      if (scan >= (id_w_lp+1)'(num_req_p)) scan = scan - (id_w_lp+1)'(num_req_p);
      if (!grant_found && req_cmd_v_i[scan[id_w_lp-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan[id_w_lp-1:0];
      end
    end
  end

  assign grant = grant_en & grant_found;

  always_comb begin
    req_cmd_yumi_o = '0;
    if (grant) req_cmd_yumi_o[grant_idx] = 1'b1;
  end

  always_comb begin
    req_resp_v_o = '0;
    if (mem_resp_v_i && fifo_nonempty) req_resp_v_o[head] = 1'b1;
  end

  assign req_resp_o       = mem_resp_i;
  assign mem_resp_ready_o = fifo_nonempty & req_resp_ready_i[head];
  assign pop              = mem_resp_v_i & mem_resp_ready_o;

  always_comb begin
    mem_cmd_d   = mem_cmd_q;
    mem_cmd_v_d = mem_cmd_v_q & ~mem_cmd_ready_i;
    rr_ptr_d    = rr_ptr_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (grant) begin
      mem_cmd_d        = req_cmd_arr[grant_idx];
      mem_cmd_v_d      = 1'b1;
      rr_ptr_d         = (grant_idx == id_w_lp'(num_req_p-1)) ? '0 : grant_idx + 1'b1;
      fifo_d[wr_ptr_q] = grant_idx;
      wr_ptr_d         = (wr_ptr_q == ptr_w_lp'(max_outstanding_p-1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == ptr_w_lp'(max_outstanding_p-1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({grant, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_cmd_q   <= '0;
      mem_cmd_v_q <= 1'b0;
      rr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < max_outstanding_p; i++) fifo_q[i] <= '0;
    end else begin
      mem_cmd_q   <= mem_cmd_d;
      mem_cmd_v_q <= mem_cmd_v_d;
      rr_ptr_q    <= rr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      fifo_q      <= fifo_d;
    end
  end

  assign mem_cmd_o     = mem_cmd_q;
  assign mem_cmd_v_o   = mem_cmd_v_q;
  assign outstanding_o = count_q;

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// tb/tb_bp_me_mem_cmd_arbiter.sv - directed scoreboard bench for bp_me_mem_cmd_arbiter
module tb_bp_me_mem_cmd_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] req_cmd;
  logic [1:0]  req_cmd_v;
  logic [1:0]  req_cmd_yumi;
  logic [15:0] mem_cmd;
  logic        mem_cmd_v;
  logic        mem_cmd_ready;
  logic [15:0] mem_resp;
  logic        mem_resp_v;
  logic        mem_resp_ready;
  logic [15:0] req_resp;
  logic [1:0]  req_resp_v;
  logic [1:0]  req_resp_ready;
  logic [2:0]  outstanding;

  int total = 0;
  int bad   = 0;

  logic [15:0] cmd_q [$];
  logic        id_q  [$];

  always #5 clk = ~clk;

  bp_me_mem_cmd_arbiter #(
    .num_req_p(2), .cmd_width_p(16), .resp_width_p(16), .max_outstanding_p(4)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_cmd_i(req_cmd), .req_cmd_v_i(req_cmd_v), .req_cmd_yumi_o(req_cmd_yumi),
    .mem_cmd_o(mem_cmd), .mem_cmd_v_o(mem_cmd_v), .mem_cmd_ready_i(mem_cmd_ready),
    .mem_resp_i(mem_resp), .mem_resp_v_i(mem_resp_v), .mem_resp_ready_o(mem_resp_ready),
    .req_resp_o(req_resp), .req_resp_v_o(req_resp_v), .req_resp_ready_i(req_resp_ready),
    .outstanding_o(outstanding)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] c, input logic id);
    cmd_q.push_back(c);
    id_q.push_back(id);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle, then score the memory command and the response routing for this cycle.
  task automatic mon();
    logic [1:0] ev;
    logic       er;
    #1;
    if (mem_cmd_v && mem_cmd_ready) begin
      if (cmd_q.size() == 0) chk("cmd_unexpected", 32'(mem_cmd_v), 32'd0);
      else                   chk("mem_cmd", 32'(mem_cmd), 32'(cmd_q.pop_front()));
    end
    ev = 2'b00;
    er = 1'b0;
    if (id_q.size() != 0) begin
      er = req_resp_ready[id_q[0]];
      if (mem_resp_v) ev[id_q[0]] = 1'b1;
    end
    chk("resp_v", 32'(req_resp_v), 32'(ev));
    chk("resp_ready", 32'(mem_resp_ready), 32'(er));
    if (mem_resp_v) chk("resp_data", 32'(req_resp), 32'(mem_resp));
    if (mem_resp_v && er) void'(id_q.pop_front());
  endtask

  initial begin
    reset_n        = 1'b0;
    req_cmd        = '0;
    req_cmd_v      = 2'b11;
    mem_cmd_ready  = 1'b1;
    mem_resp       = 16'h0;
    mem_resp_v     = 1'b0;
    req_resp_ready = 2'b11;
    #1;
    chk("rst_cmd_v", 32'(mem_cmd_v), 32'd0);
    chk("rst_cmd", 32'(mem_cmd), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_yumi", 32'(req_cmd_yumi), 32'd0);
    chk("rst_resp_v", 32'(req_resp_v), 32'd0);
    tick();
    reset_n   = 1'b1;
    req_cmd_v = 2'b00;
    tick();

    // single requester
    req_cmd   = {16'h00A5, 16'h0000};
    req_cmd_v = 2'b10;
    mon(); chk("single_yumi", 32'(req_cmd_yumi), 32'd2); push(16'h00A5, 1'b1); tick();
    req_cmd_v = 2'b00;
    mon();
    chk("single_cmd_v", 32'(mem_cmd_v), 32'd1);
    chk("single_cmd", 32'(mem_cmd), 32'h00A5);
    chk("single_outstanding", 32'(outstanding), 32'd1);
    tick();
    mem_resp = 16'h1111; mem_resp_v = 1'b1;
    mon(); tick();
    mem_resp_v = 1'b0;
    mon(); chk("single_drained", 32'(outstanding), 32'd0); tick();

    // contention with immediate responses
    req_cmd    = {16'h2001, 16'h1000};
    req_cmd_v  = 2'b11;
    mem_resp_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_resp = 16'hC000 + 16'(i);
      mon();
      chk("rr_yumi", 32'(req_cmd_yumi), (i % 2 == 0) ? 32'd1 : 32'd2);
      push((i % 2 == 0) ? 16'h1000 : 16'h2001, (i % 2) != 0);
      tick();
    end
    req_cmd_v = 2'b00;
    mon(); tick();
    mem_resp_v = 1'b0;
    mon();
    chk("rr_outstanding", 32'(outstanding), 32'd0);
    chk("rr_cmd_v", 32'(mem_cmd_v), 32'd0);
    tick();

    // backpressure
    mem_cmd_ready = 1'b0;
    req_cmd       = {16'h0000, 16'h3000};
    req_cmd_v     = 2'b01;
    mon(); chk("bp_first_yumi", 32'(req_cmd_yumi), 32'd1); push(16'h3000, 1'b0); tick();
    req_cmd = {16'h0000, 16'h3001};
    for (int i = 0; i < 3; i++) begin
      mon();
      chk("bp_no_yumi", 32'(req_cmd_yumi), 32'd0);
      chk("bp_cmd_stable", 32'(mem_cmd), 32'h3000);
      chk("bp_cmd_v", 32'(mem_cmd_v), 32'd1);
      tick();
    end
    mem_cmd_ready = 1'b1;
    mon(); chk("bp_drain_grant", 32'(req_cmd_yumi), 32'd1); push(16'h3001, 1'b0); tick();
    req_cmd_v = 2'b00;
    mon(); tick();

    // outstanding limit
    mem_resp_v = 1'b1; mem_resp = 16'h5A5A;
    mon(); tick();
    mon(); tick();
    mem_resp_v = 1'b0;
    chk("lim_start", 32'(outstanding), 32'd0);
    req_cmd   = {16'h4001, 16'h4000};
    req_cmd_v = 2'b11;
    for (int i = 0; i < 4; i++) begin
      mon();
      chk("lim_yumi", 32'(req_cmd_yumi), (i % 2 == 0) ? 32'd2 : 32'd1);
      push((i % 2 == 0) ? 16'h4001 : 16'h4000, (i % 2) == 0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      mon();
      chk("lim_full_yumi", 32'(req_cmd_yumi), 32'd0);
      chk("lim_full", 32'(outstanding), 32'd4);
      tick();
    end
    mem_resp_v = 1'b1; mem_resp = 16'h6666;
    mon(); chk("lim_pop_no_grant", 32'(req_cmd_yumi), 32'd0); tick();
    mem_resp_v = 1'b0;
    mon(); chk("lim_grant_after_pop", 32'(req_cmd_yumi), 32'd2); push(16'h4001, 1'b1); tick();
    req_cmd_v = 2'b00;

    // response stall on head=1
    mem_resp_v = 1'b1; mem_resp = 16'h7777;
    mon(); tick();
    req_resp_ready = 2'b01;
    mon(); tick();
    mon(); chk("stall_outstanding", 32'(outstanding), 32'd3); tick();
    req_resp_ready = 2'b11;
    mon(); tick();
    mem_resp_v = 1'b0;
    chk("stall_released", 32'(outstanding), 32'd2);

    // reset mid-operation
    mem_cmd_ready = 1'b0;
    req_cmd       = {16'h0000, 16'h6000};
    req_cmd_v     = 2'b01;
    mon(); chk("mid_yumi", 32'(req_cmd_yumi), 32'd1); push(16'h6000, 1'b0); tick();
    mon();
    chk("mid_outstanding", 32'(outstanding), 32'd3);
    chk("mid_cmd_v", 32'(mem_cmd_v), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cmd_v", 32'(mem_cmd_v), 32'd0);
    chk("mid_rst_outstanding", 32'(outstanding), 32'd0);
    chk("mid_rst_yumi", 32'(req_cmd_yumi), 32'd0);
    cmd_q.delete();
    id_q.delete();
    tick();
    reset_n       = 1'b1;
    mem_cmd_ready = 1'b1;
    req_cmd       = {16'h7001, 16'h7000};
    req_cmd_v     = 2'b11;
    mon(); chk("post_rst_yumi", 32'(req_cmd_yumi), 32'd1); push(16'h7000, 1'b0); tick();
    req_cmd_v = 2'b00;
    mon(); chk("post_rst_outstanding", 32'(outstanding), 32'd1); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_me_mem_cmd_arbiter.md
Name: bp_me_mem_cmd_arbiter

Overview:
- Shares one memory command/response port between num_req_p CCE memory interfaces in the tiled top.
- Picks one requester per cycle with round-robin arbitration and forwards its command through a one-entry output register.
- Records the source ID of every granted command in an in-order outstanding FIFO.
- Routes each memory response back to the requester at the FIFO head. Memory returns responses in command order.

Parameters:
- num_req_p, 2: number of requesting CCEs; must be >= 2.
- cmd_width_p, 128: width of the opaque command payload.
- resp_width_p, 128: width of the opaque response payload.
- max_outstanding_p, 4: depth of the outstanding-ID FIFO, i.e. the maximum number of granted but unanswered commands; must be >= 1.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- req_cmd_i  in  num_req_p*cmd_width_p  per-requester commands; requester k occupies slice k.
- req_cmd_v_i  in  num_req_p  per-requester command valid.
- req_cmd_yumi_o  out  num_req_p  per-requester command consumed this cycle.
- mem_cmd_o  out  cmd_width_p  command to memory.
- mem_cmd_v_o  out  1  command valid to memory.
- mem_cmd_ready_i  in  1  memory accepts the command.
- mem_resp_i  in  resp_width_p  response from memory.
- mem_resp_v_i  in  1  response valid from memory.
- mem_resp_ready_o  out  1  response accepted from memory.
- req_resp_o  out  resp_width_p  response data, broadcast to all requesters.
- req_resp_v_o  out  num_req_p  one-hot response valid.
- req_resp_ready_i  in  num_req_p  per-requester response ready.
- outstanding_o  out  clog2(max_outstanding_p+1)  current FIFO occupancy.

Behaviour:
- Reset
  - One clock; reset is asynchronous and active-low on reset_n_i.
  - On assertion: mem_cmd_v_o=0, mem_cmd_o=0, rr_ptr=0, FIFO empty, outstanding_o=0.
  - All yumi and response valids are 0 while reset is asserted.
  - Reset in the middle of operation discards the buffered command and all outstanding IDs. Responses for those commands are not recovered.
- Output slot
  - The slot is free when mem_cmd_v_o=0, or when mem_cmd_v_o & mem_cmd_ready_i (it drains this cycle).
  - The slot holds its data stable while mem_cmd_v_o=1 & mem_cmd_ready_i=0.
- Grant
  - Grant is enabled when the slot is free and outstanding_o < max_outstanding_p.
  - A pop in the same cycle does not free FIFO space for a grant in that cycle.
  - When enabled, grant the first k with req_cmd_v_i[k]=1, scanning rr_ptr, rr_ptr+1, ... modulo num_req_p.
  - req_cmd_yumi_o[k]=1 in the same cycle (combinational, valid/yumi protocol). At most one yumi bit is high.
  - On grant, the next edge loads mem_cmd_o=req_cmd_i[k], sets mem_cmd_v_o=1, pushes k into the FIFO, and sets rr_ptr=(k+1) mod num_req_p.
  - With no grant: rr_ptr is unchanged, and mem_cmd_v_o clears if the slot drained.
  - Throughput is one command per cycle while memory is ready. Latency from yumi to mem_cmd_v_o is 1 cycle.
- Response routing
  - Let head = FIFO front ID.
  - req_resp_v_o[head] = mem_resp_v_i & (FIFO nonempty); all other bits are 0.
  - req_resp_o = mem_resp_i, passed through combinationally with zero latency.
  - mem_resp_ready_o = (FIFO nonempty) & req_resp_ready_i[head].
  - On mem_resp_v_i & mem_resp_ready_o, pop the FIFO.
  - A response arriving while the FIFO is empty is protocol error. The block holds mem_resp_ready_o=0 and asserts no valid.
- Occupancy
  - Push and pop in the same cycle leave occupancy unchanged.
  - outstanding_o is registered and never exceeds max_outstanding_p.
  - FIFO read and write pointers wrap modulo max_outstanding_p.

Test Plan:
- Single requester: req 1 holds cmd 0xA5 valid, memory always ready → yumi[1] in cycle 0; mem_cmd_o=0xA5 with v=1 in cycle 1; outstanding_o=1; rr_ptr=0.
- Contention: both requesters valid continuously, memory ready, responses returned immediately → grant order 0,1,0,1; each requester sees exactly its own response in order.
- Backpressure: mem_cmd_ready_i=0 for 3 cycles with the slot full → mem_cmd_o stable, no yumi. Ready rises → drain and new grant in the same cycle.
- Outstanding limit (max_outstanding_p=4): 4 grants, no responses → outstanding_o=4, no yumi. One response popped → a grant occurs the following cycle, not the same cycle.
- Response stall: head=1, req_resp_ready_i[1]=0 with mem_resp_v_i=1 → mem_resp_ready_o=0, FIFO unchanged. Ready goes 1 → pop, outstanding_o decrements.
- Reset mid-operation: assert reset_n_i=0 with 3 outstanding and the slot full → mem_cmd_v_o=0 and outstanding_o=0 immediately. After release, the first grant goes to requester 0.
